// File: rtl/alu_multdiv.sv
// Registered integer ALU with an iterative signed shift-add multiplier and restoring divider.
// Single-cycle ops complete on the accept edge; MUL/DIV complete WIDTH+1 edges after accept.
module alu_multdiv #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_operandA,
   input  logic [WIDTH-1:0]   data_operandB,
   input  logic [4:0]         ctrl_ALUopcode,
   input  logic [SHAMT_W-1:0] ctrl_shiftamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   data_result,
   output logic               isNotEqual,
   output logic               isLessThan,
   output logic               overflow,
   output logic               data_exception
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_SLL = 5'd4;
   localparam logic [4:0] OP_SRA = 5'd5;
   localparam logic [4:0] OP_MUL = 5'd6;
   localparam logic [4:0] OP_DIV = 5'd7;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_next;

   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] prod, mcand;
   logic [WIDTH-1:0]   shreg, divisor, rem;
   logic               pend_div, pend_neg, pend_ne, pend_lt, pend_dbz, pend_min_ovf;

   logic [WIDTH-1:0]   sum, diff, mag_a, mag_b, alu_res, fix_res, quot_signed;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     rem_shift, rem_sub;
   logic [2*WIDTH-1:0] prod_signed;
   logic add_ovf, sub_ovf, cmp_ne, cmp_lt, alu_ovf, known_op, is_iter, accept, rem_ge;
   logic fix_ovf, fix_exc;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign is_iter  = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);

   always_comb begin
      sum      = data_operandA + data_operandB;
      diff     = data_operandA - data_operandB;
      add_ovf  = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) && (sum[WIDTH-1] != data_operandA[WIDTH-1]);
      sub_ovf  = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) && (diff[WIDTH-1] != data_operandA[WIDTH-1]);
      cmp_ne   = (data_operandA != data_operandB);
      cmp_lt   = diff[WIDTH-1] ^ sub_ovf;
      mag_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      shamt    = SHAMT_W'(32'(ctrl_shiftamt) % 32'(WIDTH));
      alu_res  = '0;
      alu_ovf  = 1'b0;
      known_op = 1'b1;
      case (ctrl_ALUopcode)
         OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
         OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
         OP_AND: alu_res = data_operandA & data_operandB;
         OP_OR:  alu_res = data_operandA | data_operandB;
         OP_SLL: alu_res = data_operandA << shamt;
         OP_SRA: alu_res = WIDTH'($signed(data_operandA) >>> shamt);
         OP_MUL, OP_DIV: alu_res = '0;
         default: known_op = 1'b0;
      endcase
   end

   // Restoring-division step: the sign of the trial subtraction decides the quotient bit.
   always_comb begin
      rem_shift   = {rem, shreg[WIDTH-1]};
      rem_sub     = rem_shift - {1'b0, divisor};
      rem_ge      = !rem_sub[WIDTH];
      prod_signed = pend_neg ? -prod : prod;
      quot_signed = pend_neg ? -shreg : shreg;
      fix_res     = prod_signed[WIDTH-1:0];
      fix_ovf     = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
      fix_exc     = 1'b0;
      if (pend_div) begin
         fix_res = pend_dbz ? '0 : quot_signed;
         fix_ovf = pend_min_ovf;
         fix_exc = pend_dbz;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && is_iter) state_next = BUSY;
         BUSY:    if (count == CNT_W'(WIDTH)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, iteration and result registers; results hold until the next completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid      <= 1'b0;
         data_result    <= '0;
         isNotEqual     <= 1'b0;
         isLessThan     <= 1'b0;
         overflow       <= 1'b0;
         data_exception <= 1'b0;
         count          <= '0;
         prod           <= '0;
         mcand          <= '0;
         shreg          <= '0;
         divisor        <= '0;
         rem            <= '0;
         pend_div       <= 1'b0;
         pend_neg       <= 1'b0;
         pend_ne        <= 1'b0;
         pend_lt        <= 1'b0;
         pend_dbz       <= 1'b0;
         pend_min_ovf   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            if (is_iter) begin
               count        <= '0;
               pend_div     <= (ctrl_ALUopcode == OP_DIV);
               pend_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               pend_ne      <= cmp_ne;
               pend_lt      <= cmp_lt;
               pend_dbz     <= (ctrl_ALUopcode == OP_DIV) && (data_operandB == '0);
               pend_min_ovf <= (ctrl_ALUopcode == OP_DIV) && (data_operandA == MIN_VAL) && (&data_operandB);
               prod         <= '0;
               mcand        <= {{WIDTH{1'b0}}, mag_a};
               shreg        <= (ctrl_ALUopcode == OP_DIV) ? mag_a : mag_b;
               divisor      <= mag_b;
               rem          <= '0;
            end else begin
               out_valid      <= 1'b1;
               data_result    <= alu_res;
               isNotEqual     <= known_op & cmp_ne;
               isLessThan     <= known_op & cmp_lt;
               overflow       <= alu_ovf;
               data_exception <= 1'b0;
            end
         end else if (state == BUSY) begin
            if (count == CNT_W'(WIDTH)) begin
               out_valid      <= 1'b1;
               data_result    <= fix_res;
               isNotEqual     <= pend_ne;
               isLessThan     <= pend_lt;
               overflow       <= fix_ovf;
               data_exception <= fix_exc;
            end else begin
               count <= count + 1'b1;
               if (pend_div) begin
                  shreg <= {shreg[WIDTH-2:0], rem_ge};
                  rem   <= rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
               end else begin
                  if (shreg[0]) prod <= prod + mcand;
                  mcand <= mcand << 1;
                  shreg <= shreg >> 1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_multdiv.sv
// Bench for alu_multdiv: directed spec vectors plus randomized traffic, checked every cycle
// against a cycle-level arithmetic model built on 64-bit integer math.
module tb_alu_multdiv;
   localparam int WIDTH    = 32;
   localparam int SHAMT_W  = 5;
   localparam int LAT_ITER = WIDTH + 1;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [WIDTH-1:0]   data_operandA = '0;
   logic [WIDTH-1:0]   data_operandB = '0;
   logic [4:0]         ctrl_ALUopcode = '0;
   logic [SHAMT_W-1:0] ctrl_shiftamt = '0;
   logic               out_valid;
   logic [WIDTH-1:0]   data_result;
   logic               isNotEqual, isLessThan, overflow, data_exception;

   alu_multdiv #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
      .out_valid(out_valid), .data_result(data_result), .isNotEqual(isNotEqual),
      .isLessThan(isLessThan), .overflow(overflow), .data_exception(data_exception)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] res;
      logic        ne;
      logic        lt;
      logic        ovf;
      logic        exc;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   int   pend_edge = 0;
   logic model_live = 1'b0;
   logic exp_ready = 1'b1;
   logic exp_valid = 1'b0;
   logic pend_active = 1'b0;
   exp_t exp_out = '0;
   exp_t pend = '0;
   exp_t pin;

   // Outputs of one operation, straight from signed integer arithmetic.
   function automatic exp_t model_op(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh);
      exp_t   e;
      longint sa, sb, r, max_v, min_v;
      max_v = 64'sd2147483647;
      min_v = -max_v - 1;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e     = '0;
      if (op > 5'd7) return e;
      e.ne = (a != b);
      e.lt = (sa < sb);
      case (op)
         5'd0: begin r = sa + sb; e.res = r[31:0]; e.ovf = (r > max_v) || (r < min_v); end
         5'd1: begin r = sa - sb; e.res = r[31:0]; e.ovf = (r > max_v) || (r < min_v); end
         5'd2: e.res = a & b;
         5'd3: e.res = a | b;
         5'd4: e.res = a << sh;
         5'd5: e.res = 32'($signed(a) >>> sh);
         5'd6: begin r = sa * sb; e.res = r[31:0]; e.ovf = (r > max_v) || (r < min_v); end
         default: begin
            if (b == 32'd0) e.exc = 1'b1;
            else begin r = sa / sb; e.res = r[31:0]; e.ovf = (r > max_v); end
         end
      endcase
      return e;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Cycle model: tracks busy window, completion edge and held output values.
   always @(posedge clock) begin
      edge_cnt <= edge_cnt + 1;
      if (reset) begin
         model_live  <= 1'b1;
         exp_ready   <= 1'b1;
         exp_valid   <= 1'b0;
         exp_out     <= '0;
         pend_active <= 1'b0;
      end else begin
         exp_valid <= 1'b0;
         if (pend_active) begin
            if (edge_cnt == pend_edge) begin
               exp_out     <= pend;
               exp_valid   <= 1'b1;
               pend_active <= 1'b0;
               exp_ready   <= 1'b1;
            end
         end else if (in_valid) begin
            if (ctrl_ALUopcode == 5'd6 || ctrl_ALUopcode == 5'd7) begin
               pend        <= model_op(ctrl_ALUopcode, data_operandA, data_operandB, ctrl_shiftamt);
               pend_active <= 1'b1;
               pend_edge   <= edge_cnt + LAT_ITER;
               exp_ready   <= 1'b0;
            end else begin
               exp_out   <= model_op(ctrl_ALUopcode, data_operandA, data_operandB, ctrl_shiftamt);
               exp_valid <= 1'b1;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (model_live) begin
         check("in_ready", 64'(in_ready), 64'(exp_ready));
         check("out_valid", 64'(out_valid), 64'(exp_valid));
         check("data_result", 64'(data_result), 64'(exp_out.res));
         check("isNotEqual", 64'(isNotEqual), 64'(exp_out.ne));
         check("isLessThan", 64'(isLessThan), 64'(exp_out.lt));
         check("overflow", 64'(overflow), 64'(exp_out.ovf));
         check("data_exception", 64'(data_exception), 64'(exp_out.exc));
      end
   end

   task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic hold);
      int guard = 0;
      while (!exp_ready && guard < 100) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (!exp_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_wait: got in_ready never expected within 100 cycles");
      end
      in_valid       = 1'b1;
      ctrl_ALUopcode = op;
      data_operandA  = a;
      data_operandB  = b;
      ctrl_shiftamt  = sh;
      @(posedge clock);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic check_output(input string name, input logic [31:0] res, input logic ne,
                               input logic lt, input logic ovf, input logic exc, input int lat);
      int n = 0;
      @(negedge clock);
      while (!out_valid && n < 40) begin
         @(negedge clock);
         n++;
      end
      in_valid = 1'b0;
      check({name, "_latency"}, 64'(n), 64'(lat));
      check({name, "_result"}, 64'(data_result), 64'(res));
      check({name, "_ne"}, 64'(isNotEqual), 64'(ne));
      check({name, "_lt"}, 64'(isLessThan), 64'(lt));
      check({name, "_ovf"}, 64'(overflow), 64'(ovf));
      check({name, "_exc"}, 64'(data_exception), 64'(exc));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      pin = model_op(5'd6, 32'hFFFF_FFFD, 32'd7, 5'd0);
      check("pin_mul", 64'(pin.res), 64'hFFFF_FFEB);
      pin = model_op(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      check("pin_div_res", 64'(pin.res), 64'h8000_0000);
      check("pin_div_ovf", 64'(pin.ovf), 64'd1);
      pin = model_op(5'd1, 32'h8000_0000, 32'd1, 5'd0);
      check("pin_sub_ovf", 64'({pin.ovf, pin.lt}), 64'b11);

      apply_stimulus(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
      check_output("add_max", 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      apply_stimulus(5'd1, 32'd5, 32'd7, 5'd0, 1'b0);
      check_output("sub_5_7", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      apply_stimulus(5'd1, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
      check_output("sub_min", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      apply_stimulus(5'd6, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b1);
      check_output("mul_m3_7", 32'hFFFF_FFEB, 1'b1, 1'b1, 1'b0, 1'b0, LAT_ITER);
      apply_stimulus(5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0);
      check_output("mul_2p32", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, LAT_ITER);
      apply_stimulus(5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
      check_output("mul_m1_m1", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, LAT_ITER);
      apply_stimulus(5'd7, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
      check_output("div_m7_2", 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 1'b0, LAT_ITER);
      apply_stimulus(5'd7, 32'd5, 32'd0, 5'd0, 1'b0);
      check_output("div_by_0", 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, LAT_ITER);
      apply_stimulus(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
      check_output("div_min_m1", 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, LAT_ITER);
      apply_stimulus(5'd4, 32'd1, 32'd0, 5'd31, 1'b0);
      check_output("sll_31", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      apply_stimulus(5'd5, 32'h8000_0000, 32'd0, 5'd4, 1'b0);
      check_output("sra_4", 32'hF800_0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      apply_stimulus(5'd9, 32'd1, 32'd2, 5'd0, 1'b0);
      check_output("bad_op", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      apply_stimulus(5'd6, 32'd12345, 32'd678, 5'd0, 1'b0);
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      apply_stimulus(5'd0, 32'd2, 32'd3, 5'd0, 1'b0);
      check_output("add_after_rst", 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 0);

      for (int i = 0; i < 3000; i++) begin
         in_valid       = ($urandom_range(0, 3) != 0);
         ctrl_ALUopcode = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         data_operandA  = rand_operand();
         data_operandB  = rand_operand();
         ctrl_shiftamt  = 5'($urandom);
         reset          = ($urandom_range(0, 999) == 0);
         @(posedge clock);
         #1;
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
